// File: rtl/mips_pkg.sv
// Shared types and widths for the register file write path.
// Imported by the writeback queue and its storage.
package mips_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;
  localparam int REG_W    = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_storage.sv
// Circular buffer of pending register writes with valid bits.
// Exposes the head entry and per-entry register match vectors.
module wbq_storage
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [REG_W-1:0] query_a_i,
  input  logic [REG_W-1:0] query_b_i,
  output wb_entry_t        head_o,
  output logic [DEPTH-1:0] match_a_o,
  output logic [DEPTH-1:0] match_b_o
);

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [DEPTH-1:0] valid_q;
  wb_entry_t        entries_q [DEPTH];

  // Pointers and valid bits; power-of-two depth makes wrap free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
    end
  end

  // Payload storage; only valid bits need reset.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      entries_q[tail_q] <= push_entry_i;
    end
  end

  assign head_o = entries_q[head_q];

  // Per-entry hit against both query indices.
  always_comb begin
    match_a_o = '0;
    match_b_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a_o[i] = valid_q[i] &&
        (entries_q[i].reg_idx == query_a_i);
      match_b_o[i] = valid_q[i] &&
        (entries_q[i].reg_idx == query_b_i);
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order write queue in front of the register file write port.
// Drains one entry per cycle and flags registers with writes in flight.
module regfile_writeback_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              flush,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  query_reg_a,
  input  logic [REG_W-1:0]  query_reg_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]     count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  assign in_ready   = (count_q != FULL) && rst_n;
  assign push       = in_valid && in_ready && !flush;
  assign pop        = (count_q != '0) && !hold && !flush;
  assign push_entry = '{reg_idx: in_reg, data: in_data};

  wbq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .clear_i      (flush),
    .query_a_i    (query_reg_a),
    .query_b_i    (query_reg_b),
    .head_o       (head),
    .match_a_o    (match_a),
    .match_b_o    (match_b)
  );

  // Next occupancy and output stage; flush wins over push and pop.
  always_comb begin
    count_d   = count_q;
    wr_en_d   = pop;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (pop) begin
      wr_reg_d  = head.reg_idx;
      wr_data_d = head.data;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign count   = count_q;
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

  // Queue hits plus the write sitting on the register file port.
  assign busy_a = (|match_a) ||
    (wr_en_q && (wr_reg_q == query_reg_a));
  assign busy_b = (|match_b) ||
    (wr_en_q && (wr_reg_q == query_reg_b));

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for the writeback queue.
// Inputs change 2ns after each rising edge; checks 1ns later.
module tb_regfile_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [31:0] in_data;
  logic        hold;
  logic        flush;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [31:0] wr_data;
  logic [3:0]  query_reg_a;
  logic [3:0]  query_reg_b;
  logic        busy_a;
  logic        busy_b;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  regfile_writeback_queue #(
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_reg      (in_reg),
    .in_data     (in_data),
    .hold        (hold),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .query_reg_a (query_reg_a),
    .query_reg_b (query_reg_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_reg = '0;
    in_data = '0;
    hold = 1'b0;
    flush = 1'b0;
    query_reg_a = '0;
    query_reg_b = '0;
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_reg", 32'(wr_reg), 0);
    chk("rst_wr_data", wr_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);

    // Single push to reg 3.
    in_valid = 1'b1;
    in_reg = 4'd3;
    in_data = 32'hDEADBEEF;
    query_reg_a = 4'd3;
    query_reg_b = 4'd0;
    #1;
    chk("s_busy_offer", 32'(busy_a), 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("s_count1", 32'(count), 1);
    chk("s_wr_en0", 32'(wr_en), 0);
    chk("s_busy_q", 32'(busy_a), 1);
    tick();
    #1;
    chk("s_wr_en1", 32'(wr_en), 1);
    chk("s_wr_reg", 32'(wr_reg), 3);
    chk("s_wr_data", wr_data, 32'hDEADBEEF);
    chk("s_count0", 32'(count), 0);
    chk("s_busy_wr", 32'(busy_a), 1);
    tick();
    #1;
    chk("s_wr_en_off", 32'(wr_en), 0);
    chk("s_busy_off", 32'(busy_a), 0);
    chk("s_data_hold", wr_data, 32'hDEADBEEF);

    // Fill with hold, reject a fifth push, then drain.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_reg = 4'(i);
      in_data = 32'h10 + 32'(i);
      tick();
    end
    in_reg = 4'd9;
    in_data = 32'h99;
    query_reg_b = 4'd9;
    #1;
    chk("f_count4", 32'(count), 4);
    chk("f_ready0", 32'(in_ready), 0);
    tick();
    #1;
    chk("f_count_hold", 32'(count), 4);
    chk("f_wr_en_hold", 32'(wr_en), 0);
    chk("f_busy9", 32'(busy_b), 0);
    in_valid = 1'b0;
    hold = 1'b0;
    tick();
    #1;
    chk("f_ready1", 32'(in_ready), 1);
    chk("f_count3", 32'(count), 3);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        tick();
        #1;
      end
      chk($sformatf("f_en%0d", i), 32'(wr_en), 1);
      chk($sformatf("f_reg%0d", i), 32'(wr_reg), 32'(i));
      chk($sformatf("f_dat%0d", i), wr_data, 32'h10 + 32'(i));
    end
    tick();
    #1;
    chk("f_done_en", 32'(wr_en), 0);
    chk("f_done_cnt", 32'(count), 0);

    // Duplicate destination reg 5.
    query_reg_a = 4'd5;
    in_valid = 1'b1;
    in_reg = 4'd5;
    in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    #1;
    chk("d_data1", wr_data, 32'h1);
    chk("d_busy1", 32'(busy_a), 1);
    chk("d_count", 32'(count), 1);
    tick();
    #1;
    chk("d_data2", wr_data, 32'h2);
    chk("d_busy2", 32'(busy_a), 1);
    tick();
    #1;
    chk("d_busy_off", 32'(busy_a), 0);

    // Flush with three queued plus a simultaneous push.
    hold = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      in_valid = 1'b1;
      in_reg = 4'(i);
      in_data = 32'h60 + 32'(i);
      tick();
    end
    flush = 1'b1;
    hold = 1'b0;
    in_reg = 4'd10;
    in_data = 32'hAA;
    query_reg_a = 4'd6;
    query_reg_b = 4'd10;
    #1;
    chk("fl_count3", 32'(count), 3);
    chk("fl_ready_pre", 32'(in_ready), 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_count0", 32'(count), 0);
    chk("fl_wr_en", 32'(wr_en), 0);
    chk("fl_busy_a", 32'(busy_a), 0);
    chk("fl_busy_b", 32'(busy_b), 0);
    tick();
    #1;
    chk("fl_no_drop", 32'(wr_en), 0);

    // Continuous stream of ten writes.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_reg = 4'(i);
      in_data = 32'h100 + 32'(i);
      tick();
      #1;
      chk($sformatf("c_cnt%0d", i), 32'(count), 1);
      if (i == 0) begin
        chk("c_en0", 32'(wr_en), 0);
      end else begin
        chk($sformatf("c_en%0d", i), 32'(wr_en), 1);
        chk($sformatf("c_reg%0d", i), 32'(wr_reg), 32'(i - 1));
        chk($sformatf("c_dat%0d", i), wr_data, 32'h100 + 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    #1;
    chk("c_last_reg", 32'(wr_reg), 9);
    chk("c_last_dat", wr_data, 32'h109);
    chk("c_last_cnt", 32'(count), 0);
    tick();
    #1;
    chk("c_idle", 32'(wr_en), 0);

    // Asynchronous reset mid-drain.
    hold = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      in_valid = 1'b1;
      in_reg = 4'(i);
      in_data = 32'hB0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    hold = 1'b0;
    query_reg_a = 4'd12;
    tick();
    #1;
    chk("r_en_pre", 32'(wr_en), 1);
    chk("r_reg_pre", 32'(wr_reg), 11);
    chk("r_cnt_pre", 32'(count), 2);
    rst_n = 1'b0;
    #1;
    chk("r_en_async", 32'(wr_en), 0);
    chk("r_cnt_async", 32'(count), 0);
    chk("r_ready_async", 32'(in_ready), 0);
    chk("r_busy", 32'(busy_a), 0);
    tick();
    #1;
    chk("r_ready_held", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("r_ready_rel", 32'(in_ready), 1);
    tick();
    #1;
    chk("r_en_rel", 32'(wr_en), 0);
    chk("r_cnt_rel", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
